seg7_scan_capture: RTL and testbench
====================================

Name: seg7_scan_capture

Overview:
- Receive-side counterpart of the 4-digit multiplexed seven-segment driver.
- Samples the active-low Anode/Cathodes scan bus, filters out transition glitches, and decodes each segment pattern back to a hex nibble.
- Assembles one 16-bit display word per full scan and reports it with a one-cycle valid pulse.
- Used in board-level loopback self-test and in the display-verification harness.

Parameters:
- STABLE_CYCLES, 16: consecutive identical samples required before a phase is accepted (min 2).
- TIMEOUT, 500000: clocks without an accepted digit before the partial frame is discarded.
- CW, 20: width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Anode  in  4  active-low digit enables. 1110=digit0 (rightmost), 1101=digit1, 1011=digit2, 0111=digit3.
- Cathodes  in  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- Value  out  16  captured word, digit3 in [15:12] through digit0 in [3:0].
- Blank  out  4  per-digit flag: that slot showed 1111111.
- Frame_valid  out  1  one-cycle pulse; Value/Blank are updated in the same cycle.
- Err_anode  out  1  one-cycle pulse on an accepted illegal anode pattern.
- Err_seg  out  1  one-cycle pulse on an accepted undecodable segment pattern.
- Stale  out  1  level; timeout expired, cleared by the next Frame_valid.

Behaviour:
- Reset values: Value=0, Blank=0, Frame_valid=0, Err_anode=0, Err_seg=0, Stale=0. Seen mask=0, stability counter=0, FSM=WAIT_STABLE, both sync stages=all ones.
- Input path: 2-FF synchroniser on the 11-bit {Anode,Cathodes}. Decode latency from the input pins is 2 sync cycles + STABLE_CYCLES + 1 output register.
- Stability filter:
  - Counter resets to 1 whenever the synchronised sample differs from the previous sample; otherwise it increments.
  - Counter saturates at STABLE_CYCLES.
- FSM states:
  - WAIT_STABLE: on the counter reaching STABLE_CYCLES, go to ACCEPT.
  - ACCEPT: single cycle. Process the sample, then go to HOLD.
  - HOLD: go to WAIT_STABLE on any sample change. A stable sample is never processed twice.
- ACCEPT processing:
  - Anode 1111 (all off): ignored, no error.
  - Anode not one-hot-low and not 1111: Err_anode pulse, mask unchanged.
  - Legal anode: decode Cathodes to nibble N using this table:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000
    - 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011
    - C=1000110, d=0100001, E=0000110, F=0001110
  - Decode outcomes:
    - Pattern 1111111 gives N=0 and sets that slot's Blank bit.
    - Any other unlisted pattern: Err_seg pulse, N=0, Blank bit cleared.
    - In all cases, write the slot into the shadow register and set its mask bit.
- Repeat capture of an already-seen slot before frame completion: overwrite the shadow slot. This is not an error.
- Frame completion:
  - Triggered in the cycle after the mask becomes 1111.
  - Copy shadow to Value/Blank, pulse Frame_valid, clear the mask, clear Stale.
  - Value holds until the next frame.
- Timeout:
  - Counter clears on every ACCEPT with a legal anode and increments otherwise, saturating.
  - On reaching TIMEOUT: clear the mask, set Stale, keep Value.
- Simultaneous events: an ACCEPT in the timeout cycle wins. The counter clears and Stale is not set.
- Asynchronous reset mid-frame discards the partial frame immediately.
- Errors never block capture. Err_anode and Err_seg can never both pulse in one cycle.

Test Plan:
- Scan digits 0..3 showing 4,3,2,1, each held 100 clocks -> one Frame_valid with Value=16'h1234, Blank=0000.
- Insert 3-cycle glitches of Cathodes=0000000 at every phase boundary (STABLE_CYCLES=16) -> glitches ignored, Value=16'h1234.
- Drive Anode=1100 stable for 40 clocks, then a normal scan of A,b,C,d -> exactly one Err_anode, then Frame_valid with Value=16'hDCBA.
- Digit2 shows 1010101, digit1 shows 1111111, others show 8 -> one Err_seg, Value=16'h8008, Blank=0010.
- Scan digits 0,1,2 then hold Anode=1111 for TIMEOUT+10 clocks -> Stale=1, no Frame_valid. A subsequent full scan -> Frame_valid and Stale=0.
- Assert Rst_n low after 3 digits of a scan -> all outputs 0 asynchronously. After release, the first complete scan alone produces the frame.

Source files
------------

// File: rtl/seg7_scan_capture_if.sv
// Scan bus from a multiplexed 4-digit seven-segment driver plus the decoded result.
// master drives the active-low scan lines; slave is the capture block.
interface seg7_scan_capture_if;
    logic [3:0]  anode;
    logic [6:0]  cathodes;
    logic [15:0] value;
    logic [3:0]  blank;
    logic        frame_valid;
    logic        err_anode;
    logic        err_seg;
    logic        stale;

    modport master (
        output anode, cathodes,
        input  value, blank, frame_valid, err_anode, err_seg, stale
    );

    modport slave (
        input  anode, cathodes,
        output value, blank, frame_valid, err_anode, err_seg, stale
    );
endinterface

// File: rtl/seg7_scan_capture.sv
// Captures a multiplexed seven-segment scan, decodes it to a 16-bit word per full scan.
// Latency: 2 sync + STABLE_CYCLES + 1 output register; no backpressure, frames are pulsed out.
module seg7_scan_capture #(
    parameter int STABLE_CYCLES = 16,
    parameter int TIMEOUT       = 500000,
    parameter int CW            = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_capture_if.slave bus
);
    localparam int           SW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [CW-1:0] TO_MAX   = CW'(TIMEOUT);
    localparam logic [CW-1:0] TO_HIT   = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {WAIT_STABLE, ACCEPT, HOLD} state_t;

    // {valid, blank, nibble}; the all-off pattern is valid but flagged blank
    function automatic logic [5:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b1000000: seg_decode = 6'b10_0000;
            7'b1111001: seg_decode = 6'b10_0001;
            7'b0100100: seg_decode = 6'b10_0010;
            7'b0110000: seg_decode = 6'b10_0011;
            7'b0011001: seg_decode = 6'b10_0100;
            7'b0010010: seg_decode = 6'b10_0101;
            7'b0000010: seg_decode = 6'b10_0110;
            7'b1111000: seg_decode = 6'b10_0111;
            7'b0000000: seg_decode = 6'b10_1000;
            7'b0010000: seg_decode = 6'b10_1001;
            7'b0001000: seg_decode = 6'b10_1010;
            7'b0000011: seg_decode = 6'b10_1011;
            7'b1000110: seg_decode = 6'b10_1100;
            7'b0100001: seg_decode = 6'b10_1101;
            7'b0000110: seg_decode = 6'b10_1110;
            7'b0001110: seg_decode = 6'b10_1111;
            7'b1111111: seg_decode = 6'b11_0000;
            default:    seg_decode = 6'b00_0000;
        endcase
    endfunction

    logic [10:0]   sync1, sync2, prev;
    logic [SW-1:0] stab_cnt;
    logic [CW-1:0] to_cnt;
    state_t        state, state_next;
    logic [3:0]    mask, mask_next;
    logic [15:0]   shadow;
    logic [3:0]    shadow_blank;

    logic          changed;
    logic          anode_legal;
    logic [1:0]    slot;
    logic [5:0]    dec;
    logic          accept_legal;
    logic          frame_done;
    logic          timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= {bus.anode, bus.cathodes};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign changed = (sync2 != prev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stab_cnt <= '0;
        else if (changed)
            stab_cnt <= SW'(1);
        else if (stab_cnt != STAB_MAX)
            stab_cnt <= stab_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= WAIT_STABLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_STABLE: if (stab_cnt == STAB_MAX) state_next = ACCEPT;
            ACCEPT:      state_next = HOLD;
            HOLD:        if (changed || stab_cnt != STAB_MAX) state_next = WAIT_STABLE;
            default:     state_next = WAIT_STABLE;
        endcase
    end

    // prev holds the sample that completed the stable run, so ACCEPT processes it
    always_comb begin
        anode_legal = 1'b0;
        slot        = 2'd0;
        case (prev[10:7])
            4'b1110: begin anode_legal = 1'b1; slot = 2'd0; end
            4'b1101: begin anode_legal = 1'b1; slot = 2'd1; end
            4'b1011: begin anode_legal = 1'b1; slot = 2'd2; end
            4'b0111: begin anode_legal = 1'b1; slot = 2'd3; end
            default: begin anode_legal = 1'b0; slot = 2'd0; end
        endcase
    end

    assign dec          = seg_decode(prev[6:0]);
    assign accept_legal = (state == ACCEPT) && anode_legal;
    assign frame_done   = (mask == 4'hF);
    assign timeout_hit  = !accept_legal && (to_cnt == TO_HIT);

    always_comb begin
        mask_next = mask;
        if (frame_done || timeout_hit)
            mask_next = 4'h0;
        if (accept_legal)
            mask_next[slot] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask          <= 4'h0;
            shadow        <= '0;
            shadow_blank  <= 4'h0;
            to_cnt        <= '0;
            bus.value       <= '0;
            bus.blank       <= 4'h0;
            bus.frame_valid <= 1'b0;
            bus.err_anode   <= 1'b0;
            bus.err_seg     <= 1'b0;
            bus.stale       <= 1'b0;
        end else begin
            mask            <= mask_next;
            bus.frame_valid <= frame_done;
            bus.err_anode   <= (state == ACCEPT) && !anode_legal && (prev[10:7] != 4'hF);
            bus.err_seg     <= accept_legal && !dec[5];
            if (accept_legal) begin
                shadow[{slot, 2'b00} +: 4] <= dec[3:0];
                shadow_blank[slot]         <= dec[4];
                to_cnt                     <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (frame_done) begin
                bus.value <= shadow;
                bus.blank <= shadow_blank;
                bus.stale <= 1'b0;
            end else if (timeout_hit) begin
                bus.stale <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench: drives scan sequences, counts output pulses, compares against hand-computed words.
module tb_seg7_scan_capture;
    localparam int STABLE = 16;
    localparam int TO     = 400;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg7_scan_capture_if sif();

    seg7_scan_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT(TO), .CW(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          vecs = 0;
    int          miscmp = 0;
    int          n_frame = 0, n_ea = 0, n_es = 0, n_both = 0;
    logic [15:0] last_val = '0;
    logic [3:0]  last_blank = '0;
    int          f0, ea0, es0;

    always @(negedge clk) begin
        if (sif.frame_valid) begin
            n_frame    <= n_frame + 1;
            last_val   <= sif.value;
            last_blank <= sif.blank;
        end
        if (sif.err_anode)                n_ea   <= n_ea + 1;
        if (sif.err_seg)                  n_es   <= n_es + 1;
        if (sif.err_anode && sif.err_seg) n_both <= n_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic show(input logic [3:0] an, input logic [6:0] ca, input int n);
        sif.anode    = an;
        sif.cathodes = ca;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] a;
        a = 4'b0001 << d;
        return ~a;
    endfunction

    task automatic scan(input logic [15:0] w, input bit rev);
        for (int k = 0; k < 4; k++) begin
            int d;
            d = rev ? 3 - k : k;
            show(an_of(d), seg_tab[w[d*4 +: 4]], 100);
        end
        show(4'hF, 7'h7F, 20);
    endtask

    task automatic snap();
        f0  = n_frame;
        ea0 = n_ea;
        es0 = n_es;
    endtask

    initial begin
        rst_n        = 1'b0;
        sif.anode    = 4'hF;
        sif.cathodes = 7'h7F;
        #23;
        check("rst value", sif.value, 0);
        check("rst blank", sif.blank, 0);
        check("rst frame_valid", sif.frame_valid, 0);
        check("rst err_anode", sif.err_anode, 0);
        check("rst err_seg", sif.err_seg, 0);
        check("rst stale", sif.stale, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        show(4'hF, 7'h7F, 30);

        // plain scan 4,3,2,1 on digits 0..3
        snap();
        scan(16'h1234, 1'b0);
        check("t1 frames", n_frame - f0, 1);
        check("t1 value", last_val, 16'h1234);
        check("t1 blank", last_blank, 0);
        check("t1 errs", (n_ea - ea0) + (n_es - es0), 0);

        // 3-cycle all-segments-on glitch at every phase boundary
        snap();
        for (int d = 0; d < 4; d++) begin
            logic [15:0] w;
            w = 16'h1234;
            show(an_of(d), 7'b0000000, 3);
            show(an_of(d), seg_tab[w[d*4 +: 4]], 97);
        end
        show(4'hF, 7'h7F, 20);
        check("t2 frames", n_frame - f0, 1);
        check("t2 value", last_val, 16'h1234);
        check("t2 errs", (n_ea - ea0) + (n_es - es0), 0);

        // two digits enabled at once, then A,b,C,d
        snap();
        show(4'b1100, seg_tab[5], 40);
        scan(16'hDCBA, 1'b0);
        check("t3 err_anode", n_ea - ea0, 1);
        check("t3 err_seg", n_es - es0, 0);
        check("t3 frames", n_frame - f0, 1);
        check("t3 value", last_val, 16'hDCBA);

        // undecodable pattern on digit2, blank digit1
        snap();
        show(4'b1110, seg_tab[8], 100);
        show(4'b1101, 7'b1111111, 100);
        show(4'b1011, 7'b1010101, 100);
        show(4'b0111, seg_tab[8], 100);
        show(4'hF, 7'h7F, 20);
        check("t4 err_seg", n_es - es0, 1);
        check("t4 err_anode", n_ea - ea0, 0);
        check("t4 frames", n_frame - f0, 1);
        check("t4 value", last_val, 16'h8008);
        check("t4 blank", last_blank, 4'b0010);

        // partial scan then idle past the timeout
        snap();
        show(4'b1110, seg_tab[8], 100);
        show(4'b1101, seg_tab[7], 100);
        show(4'b1011, seg_tab[6], 100);
        show(4'hF, 7'h7F, TO + 10);
        check("t5 stale set", sif.stale, 1);
        check("t5 no frame", n_frame - f0, 0);
        check("t5 value kept", sif.value, 16'h8008);
        show(4'b0111, seg_tab[9], 100);
        check("t5 mask cleared", n_frame - f0, 0);
        check("t5 stale holds", sif.stale, 1);
        snap();
        scan(16'h5678, 1'b1);
        check("t5 frames", n_frame - f0, 1);
        check("t5 value", last_val, 16'h5678);
        check("t5 stale cleared", sif.stale, 0);

        // asynchronous reset after three digits
        show(4'b1110, seg_tab[15], 100);
        show(4'b1101, seg_tab[10], 100);
        show(4'b1011, seg_tab[12], 100);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6 async value", sif.value, 0);
        check("t6 async blank", sif.blank, 0);
        check("t6 async stale", sif.stale, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        snap();
        show(4'b0111, seg_tab[3], 100);
        check("t6 partial discarded", n_frame - f0, 0);
        scan(16'h4E2F, 1'b1);
        check("t6 frames", n_frame - f0, 1);
        check("t6 value", last_val, 16'h4E2F);

        check("err exclusivity", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end
endmodule
